// File: rtl/simon_pkg.sv
// simon_pkg: shared types, LFSR taps and colour decoding for the Simon sequencer.
package simon_pkg;
   typedef enum logic [2:0] {IDLE, PLAY_INIT, SHOW_ON, SHOW_OFF, INPUT_INIT, INPUT, WIN, LOSE} state_t;
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   typedef logic [1:0] colour_t;
   function automatic logic [3:0] colour_to_led(colour_t c);
      return 4'b0001 << c;
   endfunction
endpackage

// File: rtl/simon_lfsr.sv
// simon_lfsr: 32-bit Galois LFSR producing the colour sequence; a zero load becomes 1.
module simon_lfsr
   import simon_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] value,
   input  logic        adv,
   output colour_t     colour
);
   logic [31:0] q_q, q_d;
   always_comb begin
      q_d = load ? ((value == 32'h0) ? 32'h1 : value)
          : adv  ? ((q_q >> 1) ^ (q_q[0] ? LFSR_TAPS : 32'h0))
          : q_q;
   end
   always_ff @(posedge clk) begin
      if (!reset) q_q <= 32'h1;
      else        q_q <= q_d;
   end
   assign colour = q_q[1:0];
endmodule

// File: rtl/simon_seq_ctrl.sv
// simon_seq_ctrl: Simon game sequencer; plays the growing colour sequence and checks presses.
module simon_seq_ctrl
   import simon_pkg::*;
#(
   parameter int ON_CYCLES      = 12_500_000,
   parameter int OFF_CYCLES     = 6_250_000,
   parameter int TIMEOUT_CYCLES = 250_000_000,
   parameter int MAX_ROUNDS     = 32
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] seed,
   input  logic [3:0]  btn,
   output logic        rst_seedgen,
   output logic [3:0]  led,
   output logic        busy,
   output logic [5:0]  round,
   output logic        win,
   output logic        lose
);
   localparam int MAX_A = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int MAXC  = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
   localparam int TW    = (MAXC > 1) ? $clog2(MAXC) : 1;

   state_t        state_q, state_d;
   logic [31:0]   seed_q, seed_d;
   logic [5:0]    round_q, round_d, step_q, step_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    led_q, led_d;
   logic          busy_q, busy_d, win_q, win_d, lose_q, lose_d, rsg_q, rsg_d;
   logic          lfsr_load, lfsr_adv;
   colour_t       colour;
   logic [3:0]    exp_led;

   simon_lfsr u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .load   (lfsr_load),
      .value  (seed_q),
      .adv    (lfsr_adv),
      .colour (colour)
   );

   assign exp_led = colour_to_led(colour);

   always_comb begin
      state_d   = state_q;
      seed_d    = seed_q;
      round_d   = round_q;
      step_d    = step_q;
      timer_d   = timer_q;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            seed_d  = seed;
            round_d = 6'd1;
            state_d = PLAY_INIT;
         end
         PLAY_INIT, INPUT_INIT: begin
            lfsr_load = 1'b1;
            step_d    = 6'd0;
            timer_d   = '0;
            state_d   = (state_q == PLAY_INIT) ? SHOW_ON : INPUT;
         end
         SHOW_ON: begin
            timer_d = (timer_q == TW'(ON_CYCLES - 1)) ? '0 : timer_q + 1'b1;
            state_d = (timer_q == TW'(ON_CYCLES - 1)) ? SHOW_OFF : SHOW_ON;
         end
         SHOW_OFF: if (timer_q == TW'(OFF_CYCLES - 1)) begin
            timer_d  = '0;
            lfsr_adv = 1'b1;
            step_d   = step_q + 6'd1;
            state_d  = (step_d == round_q) ? INPUT_INIT : SHOW_ON;
         end else timer_d = timer_q + 1'b1;
         // exp_led is one-hot, so equality also rejects multi-bit presses
         INPUT: if (btn != 4'b0) begin
            if (btn == exp_led) begin
               lfsr_adv = 1'b1;
               step_d   = step_q + 6'd1;
               timer_d  = '0;
               if (step_d == round_q) begin
                  state_d = (round_q == 6'(MAX_ROUNDS)) ? WIN : PLAY_INIT;
                  round_d = (round_q == 6'(MAX_ROUNDS)) ? round_q : round_q + 6'd1;
               end
            end else state_d = LOSE;
         end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) state_d = LOSE;
         else timer_d = timer_q + 1'b1;
         default: state_d = IDLE;
      endcase
   end

   // outputs are registered from the current state, so they trail it by one cycle
   always_comb begin
      led_d  = (state_q == SHOW_ON) ? exp_led : 4'b0;
      busy_d = state_q != IDLE;
      win_d  = state_q == WIN;
      lose_d = state_q == LOSE;
      rsg_d  = (state_q == PLAY_INIT) && (round_q == 6'd1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         seed_q  <= 32'h0;
         round_q <= 6'd0;
         step_q  <= 6'd0;
         timer_q <= '0;
         led_q   <= 4'b0;
         busy_q  <= 1'b0;
         win_q   <= 1'b0;
         lose_q  <= 1'b0;
         rsg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         seed_q  <= seed_d;
         round_q <= round_d;
         step_q  <= step_d;
         timer_q <= timer_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         win_q   <= win_d;
         lose_q  <= lose_d;
         rsg_q   <= rsg_d;
      end
   end

   assign rst_seedgen = rsg_q;
   assign led         = led_q;
   assign busy        = busy_q;
   assign round       = round_q;
   assign win         = win_q;
   assign lose        = lose_q;
endmodule

// File: tb/tb_simon_seq_ctrl.sv
// tb_simon_seq_ctrl: directed bench with a playback scoreboard for simon_seq_ctrl.
module tb_simon_seq_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] seed = 32'h0;
   logic [3:0]  btn = 4'b0;
   logic        rst_seedgen, busy, win, lose;
   logic [3:0]  led;
   logic [5:0]  round;

   int passed = 0;
   int total  = 0;
   logic [3:0] exp_q[$];
   logic [3:0] seq [3] = '{4'b0010, 4'b1000, 4'b0100};
   logic [3:0] prev_led = 4'b0;
   int on_cnt = 0;

   simon_seq_ctrl #(
      .ON_CYCLES(4), .OFF_CYCLES(2), .TIMEOUT_CYCLES(10), .MAX_ROUNDS(3)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .seed(seed), .btn(btn),
      .rst_seedgen(rst_seedgen), .led(led), .busy(busy), .round(round),
      .win(win), .lose(lose)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // scoreboard: every colour that lights must be the next expected one and stay lit 4 cycles
   always @(negedge clk) begin
      if (led != 4'b0 && prev_led == 4'b0) begin
         chk("led_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) chk("led_colour", 32'(led), 32'(exp_q.pop_front()));
         on_cnt = 1;
      end else if (led != 4'b0) on_cnt++;
      if (led == 4'b0 && prev_led != 4'b0) chk("led_on_len", on_cnt, 4);
      prev_led = led;
   end

   task automatic start_game(input logic [31:0] s);
      seed = s;
      start = 1'b1;
      exp_q.push_back(seq[0]);
      tick(1);
      start = 1'b0;
   endtask

   task automatic to_input(input int n);
      tick(2 + 6 * n);
   endtask

   task automatic press(input logic [3:0] v);
      btn = v;
      tick(1);
      btn = 4'b0;
   endtask

   task automatic play_round(input int n, input bit last);
      to_input(n);
      for (int i = 0; i < n; i++) begin
         if (i == n - 1 && !last)
            for (int j = 0; j <= n; j++) exp_q.push_back(seq[j]);
         press(seq[i]);
         if (i < n - 1) tick(1);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      exp_q.delete();
      tick(1);
      reset = 1'b1;
   endtask

   initial begin
      // reset held with start high
      start = 1'b1;
      tick(2);
      chk("reset_outs", {26'd0, rst_seedgen, led, busy, round, win, lose}, 32'd0);
      start = 1'b0;
      reset = 1'b1;
      tick(3);
      chk("idle_outs", {26'd0, rst_seedgen, led, busy, round, win, lose}, 32'd0);

      // seed 1: start timing, first playback, ignored press in INPUT_INIT
      start_game(32'h1);
      chk("round_start", round, 1);
      chk("rsg_early", rst_seedgen, 0);
      tick(1);
      chk("rsg_pulse", rst_seedgen, 1);
      chk("busy_start", busy, 1);
      chk("led_k1", led, 0);
      tick(1);
      chk("rsg_once", rst_seedgen, 0);
      chk("led_k2", led, 4'b0010);
      for (int i = 3; i <= 7; i++) begin
         tick(1);
         chk("led_timing", led, (i <= 5) ? 4'b0010 : 4'b0000);
      end
      btn = 4'b0001;
      tick(1);
      btn = 4'b0;
      exp_q.push_back(seq[0]);
      exp_q.push_back(seq[1]);
      press(4'b0010);
      chk("round_two", round, 2);
      chk("init_press_ignored", lose, 0);
      tick(1);
      chk("led_p1", led, 0);
      tick(1);
      chk("led_p2", led, 4'b0010);
      tick(12);
      chk("pb_r2_done", 32'(exp_q.size()), 0);
      do_reset();

      // seed 0 behaves like seed 1; full game to a win
      tick(1);
      start_game(32'h0);
      play_round(1, 1'b0);
      play_round(2, 1'b0);
      play_round(3, 1'b1);
      chk("win_lag", win, 0);
      tick(1);
      chk("win_pulse", win, 1);
      chk("win_busy", busy, 1);
      tick(1);
      chk("win_end", win, 0);
      chk("win_idle", busy, 0);
      tick(3);
      chk("win_single", win, 0);
      chk("round_held", round, 3);

      // wrong colour on second press of round 2
      start_game(32'h1);
      play_round(1, 1'b0);
      to_input(2);
      press(4'b0010);
      tick(1);
      press(4'b0100);
      chk("lose_lag", lose, 0);
      tick(1);
      chk("lose_wrong", lose, 1);
      tick(1);
      chk("lose_end", lose, 0);
      chk("lose_idle", busy, 0);
      chk("lose_round", round, 2);

      // multi-bit press in round 1
      start_game(32'h1);
      to_input(1);
      press(4'b0011);
      tick(1);
      chk("lose_multi", lose, 1);
      tick(1);
      chk("multi_idle", busy, 0);

      // timeout after 10 idle INPUT cycles
      start_game(32'h1);
      to_input(1);
      tick(10);
      chk("no_early_timeout", lose, 0);
      chk("timeout_busy", busy, 1);
      tick(1);
      chk("lose_timeout", lose, 1);
      tick(1);

      // start during SHOW_ON ignored, then reset during SHOW_OFF
      start_game(32'h1);
      tick(2);
      seed = 32'hFFFF_FFFF;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(1);
      chk("start_ignored_rsg", rst_seedgen, 0);
      chk("start_ignored_round", round, 1);
      tick(1);
      chk("pb_seen", 32'(exp_q.size()), 0);
      reset = 1'b0;
      tick(1);
      chk("reset_led", led, 0);
      chk("reset_busy", busy, 0);
      chk("reset_round", round, 0);
      reset = 1'b1;
      tick(2);
      chk("reset_stays_idle", {busy, led}, 5'd0);
      chk("sb_empty", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
